ccd_line_avg: RTL and testbench
===============================

CCD_LINE_AVG -- requirements
Module: ccd_line_avg

Interface
REQ-001 Param DATA_WIDTH, default 8: pixel sample width on both AXI-Stream ports.
REQ-002 Param LINE_PIXELS, default 2048: maximum pixels per line and accumulator RAM depth.
REQ-003 pixel_clk  in  1: single clock; all logic on its rising edge.
REQ-004 rst_n  in  1: reset, asynchronous and active-low.
REQ-005 avg_log2  in  2: lines averaged per output line, N = 2^avg_log2 (1,2,4,8).
REQ-006 s_axis_tdata  in  DATA_WIDTH: input pixel from the CCD line stream.
REQ-007 s_axis_tvalid  in  1: input beat valid.
REQ-008 s_axis_tready  out  1: input beat accepted when tvalid && tready.
REQ-009 s_axis_tlast  in  1: last pixel of input line.
REQ-010 s_axis_tuser  in  1: first pixel of input frame.
REQ-011 m_axis_tdata  out  DATA_WIDTH: averaged pixel.
REQ-012 m_axis_tvalid  out  1: output beat valid.
REQ-013 m_axis_tready  in  1: downstream ready.
REQ-014 m_axis_tlast  out  1: last pixel of output line.
REQ-015 m_axis_tuser  out  1: first pixel of output frame.
REQ-016 line_err  out  1: one-cycle pulse on an overlong input line.

Function
REQ-017 Counters: pix_idx (0..LINE_PIXELS-1) and grp_line (0..N-1); both advance only on accepted beats.
REQ-018 Accumulator RAM: LINE_PIXELS x (DATA_WIDTH+3) bits, read-modify-write of entry pix_idx in the acceptance cycle; no overflow possible (8 x 255 < 2048).
REQ-019 grp_line = 0: RAM[pix_idx] <= sample; 0 < grp_line < N-1: RAM[pix_idx] <= RAM[pix_idx] + sample.
REQ-020 grp_line = N-1 (final line): no RAM write; output beat = (RAM[pix_idx] + sample) >> avg_log2, truncating; N = 1 passes samples unchanged.
REQ-021 Non-final lines: s_axis_tready = 1; no output produced.
REQ-022 Final line: single output register; s_axis_tready = !m_axis_tvalid || m_axis_tready.
REQ-023 Latency: accepted final-line beat appears on m_axis one cycle later.
REQ-024 m_axis_tdata/tlast/tuser held stable while m_axis_tvalid && !m_axis_tready; m_axis_tvalid cleared after a handshake unless a new beat is loaded in the same cycle.
REQ-025 Accepted s_axis_tlast: pix_idx <= 0; grp_line <= (grp_line = N-1) ? 0 : grp_line+1.
REQ-026 m_axis_tlast = 1 on the output beat carrying input tlast, or on pix_idx = LINE_PIXELS-1.
REQ-027 Overlong line: beats after pix_idx = LINE_PIXELS-1 and before tlast are accepted, neither written nor output; line_err pulses one cycle after that line's tlast is accepted.
REQ-028 Short line: early tlast ends the line; stale RAM entries beyond it are unused.
REQ-029 Accepted s_axis_tuser: treated as pix_idx 0 of grp_line 0 regardless of counter state; any partial group is discarded; avg_log2 is latched into avg_q.
REQ-030 avg_log2 is used only via avg_q; changes between tuser beats are ignored.
REQ-031 Frame flag: set by accepted tuser; m_axis_tuser = 1 on the first output beat while the flag is set; cleared when that beat is loaded.
REQ-032 tuser and tlast on the same beat: one-pixel line; tuser rules apply first, then tlast advance.

Reset
REQ-033 rst_n low: m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, line_err = 0; pix_idx = grp_line = 0; avg_q = 0 (N=1); frame flag cleared; RAM contents undefined.
REQ-034 Reset mid-line or mid-output: pending output beat dropped; first beat after release starts grp_line 0.

Verification
REQ-035 avg_log2=0, tuser, 2048-beat ramp (i mod 256), m_tready=1 -> identical data one cycle later, tuser on beat 0, tlast on beat 2047.
REQ-036 avg_log2=2, four lines constant 10,20,30,41 -> no output for lines 1-3; line 4 outputs 25 on every pixel (101>>2).
REQ-037 Final line, m_tready low 5 cycles mid-line -> s_tready low, m_tdata held, no pixel lost or duplicated.
REQ-038 avg_log2=2, tuser during grp_line 2 -> partial group discarded; next 4 lines yield one output line with tuser=1 on pixel 0.
REQ-039 avg_log2=0, 2050-beat line -> 2048 output beats, tlast on beat 2047, line_err pulse once.
REQ-040 rst_n low while m_tvalid=1 -> all outputs 0 immediately; next input line restarts at grp_line 0.

Source files
------------

// File: rtl/ccd_line_avg.sv
// Line averager for a CCD pixel stream. Each output line is the truncated mean
// of N = 2^avg_log2 consecutive input lines, accumulated in a per-pixel RAM.
module ccd_line_avg #(
  parameter int DATA_WIDTH  = 8,
  parameter int LINE_PIXELS = 2048
) (
  input  logic                  pixel_clk,
  input  logic                  rst_n,
  input  logic [1:0]            avg_log2,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  line_err
);

  localparam int AW = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
  localparam int SW = DATA_WIDTH + 3;

  logic [SW-1:0]         r_ram [LINE_PIXELS];
  logic [AW-1:0]         r_pix;
  logic [2:0]            r_grp;
  logic [1:0]            r_avg_q;
  logic                  r_over;
  logic                  r_frame;
  logic                  r_m_valid;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic                  r_m_last;
  logic                  r_m_user;
  logic                  r_line_err;

  logic [AW-1:0] w_pix;
  logic [2:0]    w_grp;
  logic [2:0]    w_last_grp;
  logic [1:0]    w_avg;
  logic          w_over;
  logic          w_final;
  logic          w_acc;
  logic          w_we;
  logic          w_load;
  logic          w_pix_end;
  logic [SW-1:0] w_rd;
  logic [SW-1:0] w_sum;

  // A tuser beat restarts the frame: pixel 0 of group line 0 with a fresh average.
  always_comb begin
    w_pix  = s_axis_tuser ? '0 : r_pix;
    w_grp  = s_axis_tuser ? 3'd0 : r_grp;
    w_over = s_axis_tuser ? 1'b0 : r_over;
    w_avg  = s_axis_tuser ? avg_log2 : r_avg_q;
    case (w_avg)
      2'd0:    w_last_grp = 3'd0;
      2'd1:    w_last_grp = 3'd1;
      2'd2:    w_last_grp = 3'd3;
      default: w_last_grp = 3'd7;
    endcase
    w_final       = (w_grp == w_last_grp);
    s_axis_tready = !w_final || !r_m_valid || m_axis_tready;
    w_acc         = s_axis_tvalid && s_axis_tready;
    w_rd          = r_ram[w_pix];
    w_sum         = ((w_grp == 3'd0) ? '0 : w_rd) + SW'(s_axis_tdata);
    w_pix_end     = (w_pix == AW'(LINE_PIXELS - 1));
    w_we          = w_acc && !w_over && !w_final;
    w_load        = w_acc && !w_over && w_final;
  end

  always_ff @(posedge pixel_clk) begin
    if (w_we) r_ram[w_pix] <= w_sum;
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix      <= '0;
      r_grp      <= 3'd0;
      r_avg_q    <= 2'd0;
      r_over     <= 1'b0;
      r_frame    <= 1'b0;
      r_line_err <= 1'b0;
    end else begin
      r_line_err <= w_acc && s_axis_tlast && w_over;
      if (w_acc) begin
        if (s_axis_tuser) r_avg_q <= avg_log2;
        if (s_axis_tlast) begin
          r_pix  <= '0;
          r_grp  <= w_final ? 3'd0 : 3'(w_grp + 3'd1);
          r_over <= 1'b0;
        end else begin
          // Past the last RAM slot the index parks and further beats are dropped.
          r_grp  <= w_grp;
          r_over <= w_over || w_pix_end;
          r_pix  <= (w_over || w_pix_end) ? w_pix : AW'(w_pix + AW'(1));
        end
      end
      if (w_load)                     r_frame <= 1'b0;
      else if (w_acc && s_axis_tuser) r_frame <= 1'b1;
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
      r_m_user  <= 1'b0;
    end else if (w_load) begin
      r_m_valid <= 1'b1;
      r_m_data  <= DATA_WIDTH'(w_sum >> w_avg);
      r_m_last  <= s_axis_tlast || w_pix_end;
      r_m_user  <= r_frame || s_axis_tuser;
    end else if (m_axis_tready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign m_axis_tvalid = r_m_valid;
  assign m_axis_tdata  = r_m_data;
  assign m_axis_tlast  = r_m_last;
  assign m_axis_tuser  = r_m_user;
  assign line_err      = r_line_err;

endmodule

// File: tb/tb_ccd_line_avg.sv
// Bench for ccd_line_avg: directed scenarios plus random groups, all checked
// against a per-pixel sum model of the averaging rules.
module tb_ccd_line_avg;
  localparam int DW = 8;
  localparam int LP = 2048;

  logic          pixel_clk = 0;
  logic          rst_n = 0;
  logic [1:0]    avg_log2 = 0;
  logic [DW-1:0] s_axis_tdata = 0;
  logic          s_axis_tvalid = 0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 0;
  logic          s_axis_tuser = 0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic          line_err;

  ccd_line_avg #(.DATA_WIDTH(DW), .LINE_PIXELS(LP)) dut (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .avg_log2(avg_log2),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .line_err(line_err)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct { int d; bit l; bit u; } beat_t;
  beat_t expq[$];
  int acc[LP];
  int m_pix, m_grp, m_avg;
  bit m_over, m_flag, exp_err;
  int total, bad;
  int out_cnt, tl_cnt, tu_cnt, err_cnt, stall_cnt, last_d;
  bit last_l;
  bit hold_v;
  int hold_w;
  int rdy_mode;

  function automatic void check(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d time=%0t", name, act, req, $time);
    end
  endfunction

  function automatic void model_reset();
    m_pix = 0; m_grp = 0; m_avg = 0; m_over = 0; m_flag = 0;
    exp_err = 0; hold_v = 0;
    expq.delete();
  endfunction

  function automatic void model_accept();
    int n, sum;
    beat_t e;
    if (s_axis_tuser) begin
      m_pix = 0; m_grp = 0; m_over = 0; m_avg = int'(avg_log2); m_flag = 1;
    end
    n = 1 << m_avg;
    if (!m_over) begin
      sum = (m_grp == 0) ? int'(s_axis_tdata) : acc[m_pix] + int'(s_axis_tdata);
      if (m_grp == n - 1) begin
        e.d = sum / n; e.l = s_axis_tlast || (m_pix == LP - 1); e.u = m_flag;
        expq.push_back(e);
        m_flag = 0;
      end else begin
        acc[m_pix] = sum;
      end
    end
    exp_err = s_axis_tlast && m_over;
    if (s_axis_tlast) begin
      m_pix = 0; m_grp = (m_grp == n - 1) ? 0 : m_grp + 1; m_over = 0;
    end else if (!m_over) begin
      if (m_pix == LP - 1) m_over = 1;
      else m_pix++;
    end
  endfunction

  always @(negedge pixel_clk) begin
    if (!rst_n) begin
      check("reset_outputs", int'({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, line_err}), 0);
      model_reset();
    end else begin
      beat_t e;
      int eg, ea;
      bit rdy_exp;
      check("line_err", int'(line_err), int'(exp_err));
      if (line_err) err_cnt++;
      if (hold_v) begin
        check("hold_valid", int'(m_axis_tvalid), 1);
        check("hold_beat", int'({m_axis_tdata, m_axis_tlast, m_axis_tuser}), hold_w);
      end
      hold_v = m_axis_tvalid && !m_axis_tready;
      hold_w = int'({m_axis_tdata, m_axis_tlast, m_axis_tuser});
      if (m_axis_tvalid && m_axis_tready) begin
        out_cnt++; last_d = int'(m_axis_tdata); last_l = m_axis_tlast;
        if (m_axis_tlast) tl_cnt++;
        if (m_axis_tuser) tu_cnt++;
        if (expq.size() == 0) check("unexpected_output", 1, 0);
        else begin
          e = expq.pop_front();
          check("out_data", int'(m_axis_tdata), e.d);
          check("out_tlast", int'(m_axis_tlast), int'(e.l));
          check("out_tuser", int'(m_axis_tuser), int'(e.u));
        end
      end
      exp_err = 0;
      if (s_axis_tvalid) begin
        eg = s_axis_tuser ? 0 : m_grp;
        ea = s_axis_tuser ? int'(avg_log2) : m_avg;
        rdy_exp = (eg != (1 << ea) - 1) || !m_axis_tvalid || m_axis_tready;
        check("s_tready", int'(s_axis_tready), int'(rdy_exp));
        if (!s_axis_tready) stall_cnt++;
        if (s_axis_tready) model_accept();
      end
    end
  end

  always @(posedge pixel_clk) begin
    #1;
    case (rdy_mode)
      0:       m_axis_tready = 1;
      1:       m_axis_tready = ($urandom % 4) != 0;
      default: m_axis_tready = 0;
    endcase
  end

  task automatic send_beat(input logic [DW-1:0] d, input bit last, input bit user, input logic [1:0] av);
    int w = 0;
    s_axis_tdata = d; s_axis_tlast = last; s_axis_tuser = user; avg_log2 = av;
    s_axis_tvalid = 1;
    forever begin
      @(negedge pixel_clk);
      if (s_axis_tready) break;
      w++;
      if (w > 2000) begin check("s_tready_timeout", 0, 1); break; end
    end
    @(posedge pixel_clk); #1;
    s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tuser = 0;
  endtask

  // kind: 0 constant val, 1 ramp (i mod 256), 2 random with random gaps
  task automatic send_line(input int len, input bit user, input int kind, input int val, input logic [1:0] av);
    logic [DW-1:0] d;
    for (int i = 0; i < len; i++) begin
      d = (kind == 0) ? DW'(val) : (kind == 1) ? DW'(i % 256) : DW'($urandom % 256);
      if (kind == 2 && ($urandom % 6) == 0) begin @(posedge pixel_clk); #1; end
      send_beat(d, i == len - 1, user && i == 0, (user && i == 0) ? av : 2'($urandom % 4));
    end
  endtask

  task automatic drain();
    int w = 0;
    while ((expq.size() != 0 || m_axis_tvalid) && w < 5000) begin
      @(negedge pixel_clk); w++;
    end
    if (w >= 5000) check("drain_timeout", 0, 1);
    @(posedge pixel_clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int o0, tl0, tu0, e0, s0, n, len;
    logic [1:0] av;
    rdy_mode = 0;
    repeat (3) @(posedge pixel_clk);
    #1 rst_n = 1;
    @(posedge pixel_clk); #1;

    // Pass-through ramp with N=1
    o0 = out_cnt; tl0 = tl_cnt; tu0 = tu_cnt;
    send_line(2048, 1, 1, 0, 2'd0);
    drain();
    check("ramp_count", out_cnt - o0, 2048);
    check("ramp_tlast_count", tl_cnt - tl0, 1);
    check("ramp_tuser_count", tu_cnt - tu0, 1);
    check("ramp_last_data", last_d, 255);
    check("ramp_last_flag", int'(last_l), 1);

    // Four constant lines averaged: (10+20+30+41)>>2 = 25
    o0 = out_cnt; tu0 = tu_cnt;
    send_line(16, 1, 0, 10, 2'd2);
    send_line(16, 0, 0, 20, 2'd2);
    send_line(16, 0, 0, 30, 2'd2);
    drain();
    check("avg4_no_early_output", out_cnt - o0, 0);
    send_line(16, 0, 0, 41, 2'd2);
    drain();
    check("avg4_count", out_cnt - o0, 16);
    check("avg4_data", last_d, 25);
    check("avg4_tuser_count", tu_cnt - tu0, 1);

    // Backpressure mid final line: (100+50)>>1 = 75
    o0 = out_cnt; s0 = stall_cnt;
    send_line(32, 1, 0, 100, 2'd1);
    fork
      send_line(32, 0, 0, 50, 2'd1);
      begin
        repeat (10) @(negedge pixel_clk);
        rdy_mode = 2;
        repeat (5) @(negedge pixel_clk);
        rdy_mode = 0;
      end
    join
    drain();
    check("stall_count", out_cnt - o0, 32);
    check("stall_data", last_d, 75);
    check("stall_seen", int'(stall_cnt - s0 > 0), 1);

    // tuser while in group line 2 discards the partial group: (4+8+12+16)>>2 = 10
    o0 = out_cnt; tu0 = tu_cnt;
    send_line(12, 1, 0, 200, 2'd2);
    send_line(12, 0, 0, 150, 2'd2);
    send_line(12, 1, 0, 4, 2'd2);
    send_line(12, 0, 0, 8, 2'd2);
    send_line(12, 0, 0, 12, 2'd2);
    drain();
    check("regroup_no_early_output", out_cnt - o0, 0);
    send_line(12, 0, 0, 16, 2'd2);
    drain();
    check("regroup_count", out_cnt - o0, 12);
    check("regroup_data", last_d, 10);
    check("regroup_tuser_count", tu_cnt - tu0, 1);

    // Overlong line: 2050 beats with N=1
    o0 = out_cnt; tl0 = tl_cnt; e0 = err_cnt;
    send_line(2050, 1, 1, 0, 2'd0);
    drain();
    check("overlong_count", out_cnt - o0, 2048);
    check("overlong_tlast_count", tl_cnt - tl0, 1);
    check("overlong_err_count", err_cnt - e0, 1);
    check("overlong_last_data", last_d, 255);

    // Random groups with random backpressure
    rdy_mode = 1;
    for (int g = 0; g < 12; g++) begin
      av = 2'($urandom % 4);
      n = 1 << av;
      len = 1 + int'($urandom % 24);
      for (int l = 0; l < n; l++) send_line(len, l == 0, 2, 0, av);
    end
    rdy_mode = 0;
    drain();

    // Reset with an output beat pending
    send_line(8, 1, 0, 50, 2'd1);
    rdy_mode = 2;
    @(posedge pixel_clk); #2;
    send_beat(8'd60, 0, 0, 2'd1);
    check("pre_reset_valid", int'(m_axis_tvalid), 1);
    rst_n = 0;
    #1;
    check("async_reset_outputs", int'({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, line_err}), 0);
    @(negedge pixel_clk);
    @(posedge pixel_clk); #1;
    rst_n = 1;
    rdy_mode = 0;
    o0 = out_cnt; tu0 = tu_cnt;
    send_line(8, 0, 0, 77, 2'd3);
    drain();
    check("post_reset_count", out_cnt - o0, 8);
    check("post_reset_data", last_d, 77);
    check("post_reset_tuser_count", tu_cnt - tu0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
